hilo_seq: RTL and testbench

Multicycle HI/LO sequencer for the MIPS core's multiply/divide path. Accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` issue requests from the decode stage and owns the architectural HI and LO registers. It runs the multiply over a fixed latency, runs division iteratively, and drives `busy` so the pipeline stalls `mfhi`/`mflo` until results land.

---
 rtl/hilo_pkg.sv | 32 +++
 rtl/div_iter.sv | 100 ++++++++++
 rtl/hilo_seq.sv | 162 ++++++++++++++++
 tb/tb_hilo_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// The HILO_DIV_EN build option compiles the iterative divider in.
package hilo_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'b000,
    OpMultu = 3'b001,
    OpDiv   = 3'b010,
    OpDivu  = 3'b011,
    OpMthi  = 3'b100,
    OpMtlo  = 3'b101,
    OpRsv6  = 3'b110,
    OpRsv7  = 3'b111
  } hilo_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } hilo_state_t;

  // 32 iteration edges plus one sign fix-up edge.
  localparam int unsigned DIV_LAT = 33;

  localparam hilo_op_t OP_MTHI = OpMthi;
  localparam hilo_op_t OP_MTLO = OpMtlo;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider: one quotient bit per cycle on magnitudes, then a
// combinational sign fix-up while valid is high. Built only with HILO_DIV_EN.
module div_iter
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        valid,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        run_q, run_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] dvd_raw_q, dvd_raw_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        dz_q, dz_d;
  logic [32:0] trial;

  // quo_q starts as the dividend magnitude; its MSB shifts into the
  // remainder while quotient bits shift in from the bottom.
  assign trial = {rem_q, quo_q[31]} - {1'b0, dsr_q};

  always_comb begin
    run_d     = run_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    dvd_raw_d = dvd_raw_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    if (flush) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d     = 1'b1;
      cnt_d     = 6'(DIV_LAT - 1);
      rem_d     = '0;
      quo_d     = cond_neg(dividend, is_signed & dividend[31]);
      dsr_d     = cond_neg(divisor, is_signed & divisor[31]);
      dvd_raw_d = dividend;
      negq_d    = is_signed & (dividend[31] ^ divisor[31]);
      negr_d    = is_signed & dividend[31];
      dz_d      = (divisor == 32'd0);
    end else if (run_q) begin
      if (cnt_q != 6'd0) begin
        cnt_d = cnt_q - 6'd1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      dvd_raw_q <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      dvd_raw_q <= dvd_raw_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dz_q      <= dz_d;
    end
  end

  assign valid = run_q && (cnt_q == 6'd0);
  // 0x80000000 / -1 needs no special case: negating 0x80000000 yields itself.
  assign quotient  = dz_q ? 32'hFFFF_FFFF : cond_neg(quo_q, negq_q);
  assign remainder = dz_q ? dvd_raw_q : cond_neg(rem_q, negr_q);

endmodule

// File: rtl/hilo_seq.sv
// HI/LO sequencer: fixed-latency multiply, mthi/mtlo, and (with HILO_DIV_EN)
// an iterative divide; without HILO_DIV_EN div/divu act as reserved no-ops.
module hilo_seq
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hilo_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        done_q, done_d;
  logic [63:0] mul_a, mul_b, prod;
  hilo_op_t    op_e;

  assign op_e  = hilo_op_t'(op);
  // Extending to 64 bits makes one truncated multiply serve both signednesses.
  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

`ifdef HILO_DIV_EN
  logic        div_start;
  logic        div_valid;
  logic [31:0] div_quo, div_rem;

  div_iter u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .flush     (cancel),
    .is_signed (op_e == OpDiv),
    .dividend  (a),
    .divisor   (b),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_start = (state_q == StIdle) && start && !cancel &&
                     ((op_e == OpDiv) || (op_e == OpDivu));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          case (op_e)
            OpMult, OpMultu: begin
              state_d = StMul;
              cnt_d   = 4'(MUL_LAT - 1);
              a_d     = a;
              b_d     = b;
              sgn_d   = (op_e == OpMult);
            end
`ifdef HILO_DIV_EN
            OpDiv, OpDivu: begin
              state_d = StDiv;
            end
`endif
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end
      StMul: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDiv: begin
`ifdef HILO_DIV_EN
        if (cancel) begin
          state_d = StIdle;
        end else if (div_valid) begin
          hi_d    = div_rem;
          lo_d    = div_quo;
          done_d  = 1'b1;
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Issue while busy is dropped by the FSM; flag it as a protocol error.
  assert property (@(posedge clk) disable iff (!rst_n) !(start && busy))
    else $warning("hilo_seq: start while busy ignored");

endmodule

// File: tb/tb_hilo_seq.sv
// Self-checking bench for hilo_seq: directed table, multi-cycle corner
// sequences and random ops against an arithmetic reference model.
module tb_hilo_seq;
  import hilo_pkg::*;

  localparam int unsigned MulLat = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad = 0;
  bit          div_en;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  hilo_seq #(.MUL_LAT(MulLat)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Architectural result from the instruction definitions, not the datapath.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] h0,
                                         input logic [31:0] l0);
    logic [63:0] r;
    longint      sp;
    int          sx, sy;
    r  = {h0, l0};
    sx = int'(x);
    sy = int'(y);
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        r  = sp;
      end
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: if (div_en) begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: if (div_en) begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
      3'd4: r[63:32] = x;
      3'd5: r[31:0] = x;
      default: ;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return int'(MulLat);
    if ((o == 3'd2 || o == 3'd3) && div_en) return 33;
    return 0;
  endfunction

  // Entered and left at a negedge; leaves in the done cycle so a following
  // call issues back-to-back.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    int          lat, k, bcnt;
    bit          hold_bad;
    r     = ref_op(o, x, y, hi_m, lo_m);
    lat   = lat_of(o);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 3'($urandom);
    k        = 0;
    bcnt     = 0;
    hold_bad = 1'b0;
    while (done !== 1'b1 && k < lat + 8) begin
      if (busy === 1'b1) bcnt++;
      if (hi !== hi_m || lo !== lo_m) hold_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("latency", k, lat);
    chk("busy cycles", bcnt, lat);
    chk("hilo hold", {31'd0, hold_bad}, 32'd0);
    chk("busy at done", {31'd0, busy}, 32'd0);
    chk("done pulse", {31'd0, done}, 32'd1);
    chk("hi", hi, r[63:32]);
    chk("lo", lo, r[31:0]);
    hi_m = r[63:32];
    lo_m = r[31:0];
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          is_div;
  } vec_t;

  vec_t        tbl[7];
  logic [63:0] r;
  int          k;

  initial begin
`ifdef HILO_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    tbl[0] = '{3'd4, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'h0000_0000, 1'b0};
    tbl[1] = '{3'd5, 32'h9ABC_DEF0, 32'd0,        32'h1234_5678, 32'h9ABC_DEF0, 1'b0};
    tbl[2] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    tbl[3] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
    tbl[4] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
    tbl[5] = '{3'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);

    // Directed table; later entries issue back-to-back in the prior done cycle.
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b);
      if (!tbl[i].is_div || div_en) begin
        chk("tbl hi", hi, tbl[i].hi);
        chk("tbl lo", lo, tbl[i].lo);
      end
    end

    // Cancel sampled at E2 of a multiply, then a mult the next cycle.
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("mul cancel busy", {31'd0, busy}, 32'd0);
    chk("mul cancel done", {31'd0, done}, 32'd0);
    chk("mul cancel hi", hi, hi_m);
    chk("mul cancel lo", lo, lo_m);
    do_op(3'd0, 32'd11, 32'hFFFF_FFFD);

`ifdef HILO_DIV_EN
    // Cancel sampled at E10 of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("div busy before cancel", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("div cancel busy", {31'd0, busy}, 32'd0);
    chk("div cancel done", {31'd0, done}, 32'd0);
    chk("div cancel hi", hi, hi_m);
    chk("div cancel lo", lo, lo_m);
    do_op(3'd1, 32'h0001_0000, 32'h0001_0000);
`endif

    // Cancel and start in the same idle cycle: start is dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel+start done", {31'd0, done}, 32'd0);
    chk("cancel+start hi", hi, hi_m);
    chk("cancel+start busy", {31'd0, busy}, 32'd0);

    // Start while busy is ignored.
    r = ref_op(3'd0, 32'd7, 32'd9, hi_m, lo_m);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ignored start done seen", {31'd0, done}, 32'd1);
    chk("ignored start hi", hi, r[63:32]);
    chk("ignored start lo", lo, r[31:0]);
    hi_m = r[63:32];
    lo_m = r[31:0];
    @(negedge clk);
    chk("ignored start no 2nd done", {31'd0, done}, 32'd0);
    chk("ignored start hi hold", hi, hi_m);

    // Reset mid-multiply.
    start = 1'b1; op = 3'd1; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    @(negedge clk);
    chk("postreset done", {31'd0, done}, 32'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(ro, ra, rb);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk("idle gap done", {31'd0, done}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
